// File: rtl/system_io_pkg.sv
// system_io_pkg: shared board I/O constants for the switch conditioning path
package system_io_pkg;
  localparam int SW_WIDTH = 8;
  localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int SW_SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/system_debounce_bit.sv
// system_debounce_bit: one switch channel (synchronizer, stability counter, clean level, optional edge pulse)
// Edge register is built only when SYSTEM_SWITCH_DEBOUNCE_EDGE_EN is defined.
module system_debounce_bit
  import system_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = SW_SYNC_STAGES_DEFAULT,
  parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o,
  output logic edge_o,
  output logic busy_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // any agreement with the clean level discards all progress toward a change
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = (sync == clean_q || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    clean_d = (sync != clean_q && cnt_q == CNT_MAX) ? sync : clean_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q   <= '0;
      clean_q <= RESET_VALUE;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end
  assign clean_o = clean_q;
  assign busy_o  = cnt_q != '0;
`ifdef SYSTEM_SWITCH_DEBOUNCE_EDGE_EN
  logic prev_q, edge_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RESET_VALUE;
      edge_q <= 1'b0;
    end else begin
      prev_q <= clean_q;
      edge_q <= prev_q ^ clean_q;
    end
  end
  assign edge_o = edge_q;
`else
  assign edge_o = 1'b0;
`endif
endmodule

// File: rtl/system_switch_debouncer.sv
// system_switch_debouncer: per-bit synchronize and debounce of raw slide switches for the PIO in_port
// Optional registered edge pulses when SYSTEM_SWITCH_DEBOUNCE_EDGE_EN is defined; otherwise edge_pulse is 0.
module system_switch_debouncer
  import system_io_pkg::*;
#(
  parameter int               WIDTH           = SW_WIDTH,
  parameter int               SYNC_STAGES     = SW_SYNC_STAGES_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] edge_pulse,
  output logic             busy
);
  logic [WIDTH-1:0] busy_v;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    system_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (sw_raw[i]),
      .clean_o(sw_clean[i]),
      .edge_o (edge_pulse[i]),
      .busy_o (busy_v[i])
    );
  end
  assign busy = |busy_v;
endmodule

// File: tb/tb_system_switch_debouncer.sv
// tb_system_switch_debouncer: directed scenarios plus randomized run against a sliding-window reference model
module tb_system_switch_debouncer;
  localparam int W = 8, D = 4, S = 2;
`ifdef SYSTEM_SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [W-1:0] sw_raw = '0, sw_clean, edge_pulse;
  logic busy;
  int checks = 0, errors = 0;
  logic [W-1:0] rq[$], win[$];
  logic [W-1:0] clean_m, pulse_m, chg_m;
  logic busy_m;

  system_switch_debouncer #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean), .edge_pulse(edge_pulse), .busy(busy));

  always #5 clk = ~clk;

  // Model: the synchronizer is a pure S-edge delay; a bit flips when the last D
  // synchronized samples all disagree with its clean level.
  task automatic model_reset();
    rq.delete();
    win.delete();
    for (int i = 0; i < S; i++) rq.push_back('0);
    clean_m = '0; pulse_m = '0; chg_m = '0; busy_m = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s;
    bit all_diff;
    s = rq.pop_front();
    rq.push_back(r);
    win.push_back(s);
    if (win.size() > D) void'(win.pop_front());
    pulse_m = EDGE_EN ? chg_m : '0;
    chg_m = '0;
    for (int b = 0; b < W; b++) begin
      all_diff = (win.size() == D);
      foreach (win[j]) if (win[j][b] == clean_m[b]) all_diff = 0;
      chg_m[b] = all_diff;
    end
    clean_m = clean_m ^ chg_m;
    busy_m = |(s ^ clean_m);
  endtask

  task automatic step(input logic [W-1:0] r);
    sw_raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] r);
    sw_raw = r;
    reset = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    sw_raw = 8'hFF;
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (sw_clean !== 8'h00) begin errors++; $display("FAIL reset_clean got %h exp 00", sw_clean); end
    if (edge_pulse !== 8'h00) begin errors++; $display("FAIL reset_pulse got %h exp 00", edge_pulse); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    sw_raw = 8'h00;
    reset = 1'b0;
  endtask

  task automatic test_clean_rise();
    for (int k = 1; k <= 9; k++) begin
      step(8'h01);
      checks += 3;
      if (sw_clean[0] !== (k >= 6)) begin errors++; $display("FAIL rise_clean k=%0d got %b exp %b", k, sw_clean[0], k >= 6); end
      if (edge_pulse[0] !== (EDGE_EN && k == 7)) begin errors++; $display("FAIL rise_pulse k=%0d got %b", k, edge_pulse[0]); end
      if (busy !== (k >= 3 && k <= 5)) begin errors++; $display("FAIL rise_busy k=%0d got %b", k, busy); end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 11; k++) begin
      step(k <= 3 ? 8'h09 : 8'h01);
      checks += 2;
      if (sw_clean !== 8'h01) begin errors++; $display("FAIL glitch_clean k=%0d got %h exp 01", k, sw_clean); end
      if (edge_pulse !== 8'h00) begin errors++; $display("FAIL glitch_pulse k=%0d got %h exp 00", k, edge_pulse); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
  endtask

  task automatic test_bounce();
    logic [W-1:0] seq [5] = '{8'h21, 8'h01, 8'h21, 8'h01, 8'h21};
    int pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      step(k <= 5 ? seq[k-1] : 8'h21);
      pulses += int'(edge_pulse[5]);
      checks++;
      if (sw_clean[5] !== (k >= 10)) begin errors++; $display("FAIL bounce_clean k=%0d got %b exp %b", k, sw_clean[5], k >= 10); end
    end
    checks++;
    if (pulses != (EDGE_EN ? 1 : 0)) begin errors++; $display("FAIL bounce_pulses got %0d exp %0d", pulses, EDGE_EN ? 1 : 0); end
  endtask

  task automatic test_multi();
    logic [W-1:0] exp_c, exp_p;
    apply_reset(8'h00);
    for (int k = 1; k <= 9; k++) begin
      step(8'hA5);
      exp_c = (k >= 6) ? 8'hA5 : 8'h00;
      exp_p = (EDGE_EN && k == 7) ? 8'hA5 : 8'h00;
      checks += 2;
      if (sw_clean !== exp_c) begin errors++; $display("FAIL multi_clean k=%0d got %h exp %h", k, sw_clean, exp_c); end
      if (edge_pulse !== exp_p) begin errors++; $display("FAIL multi_pulse k=%0d got %h exp %h", k, edge_pulse, exp_p); end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(8'h00);
    for (int k = 1; k <= 3; k++) step(8'h80);
    reset = 1'b1;
    #1;
    model_reset();
    checks += 2;
    if (sw_clean !== 8'h00) begin errors++; $display("FAIL midrst_clean got %h exp 00", sw_clean); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(8'h80);
      checks++;
      if (sw_clean[7] !== (k >= 6)) begin errors++; $display("FAIL midrst_restart k=%0d got %b exp %b", k, sw_clean[7], k >= 6); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] cur = '0;
    apply_reset(cur);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 5) == 0) cur = cur ^ W'($urandom);
      step(cur);
      checks += 3;
      if (sw_clean !== clean_m) begin errors++; $display("FAIL rand_clean n=%0d got %h exp %h", n, sw_clean, clean_m); end
      if (edge_pulse !== pulse_m) begin errors++; $display("FAIL rand_pulse n=%0d got %h exp %h", n, edge_pulse, pulse_m); end
      if (busy !== busy_m) begin errors++; $display("FAIL rand_busy n=%0d got %b exp %b", n, busy, busy_m); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_glitch();
    test_bounce();
    test_multi();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
